riscv_instr_mem_arbiter: RTL and testbench

- Shares one instruction-memory port (req/gnt/rvalid protocol) between two requesters.
- m0 is the core prefetch buffer; m1 is a secondary fetcher (debug unit or boot loader).
- Arbitrates round-robin, holds the selection while a request waits for grant, and records the owner of every granted transaction in an in-order ID FIFO.
- Routes each rvalid/rdata back to the master that issued the corresponding request.

---
 rtl/riscv_arb_pkg.sv | 19 +
 rtl/riscv_arb_id_fifo.sv | 88 ++++++++
 rtl/riscv_instr_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_riscv_instr_mem_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// Shared types for the two-master instruction-memory arbiter.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_HOLD_M0 = 2'd1,
    ARB_HOLD_M1 = 2'd2
  } arb_state_e;

  typedef logic arb_id_t;

  localparam arb_id_t ARB_M0 = 1'b0;
  localparam arb_id_t ARB_M1 = 1'b1;

  function automatic arb_id_t arb_other(input arb_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/riscv_arb_id_fifo.sv
// In-order FIFO of master IDs for granted transactions still awaiting rvalid.
module riscv_arb_id_fifo
  import riscv_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  arb_id_t          push_id_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output arb_id_t          head_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  arb_id_t          mem_q [DEPTH];
  arb_id_t          mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s, empty_s, do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign empty_s   = (count_q == '0);
  assign do_push_s = push_i && !full_s;
  assign do_pop_s  = pop_i && !empty_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: ARB_M0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o   = full_s;
  assign empty_o  = empty_s;
  assign head_o   = mem_q[rd_ptr_q];
  assign rd_ptr_o = rd_ptr_q;
  assign wr_ptr_o = wr_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/riscv_instr_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between the
// prefetch buffer (m0) and a secondary fetcher (m1); responses routed in order.
module riscv_instr_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e            state_q, state_d;
  arb_id_t               rr_q, rr_d;
  logic                  err_q, err_d;

  logic                  sel_valid_s;
  arb_id_t               sel_id_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic                  req_s, gnt_fire_s, pop_s;

  logic                  fifo_full_s, fifo_empty_s;
  arb_id_t               fifo_head_s;
  logic [PTR_W-1:0]      fifo_rd_ptr_s, fifo_wr_ptr_s;
  logic [CNT_W-1:0]      fifo_count_s;

  riscv_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (gnt_fire_s),
    .push_id_i(sel_id_s),
    .pop_i    (pop_s),
    .full_o   (fifo_full_s),
    .empty_o  (fifo_empty_s),
    .head_o   (fifo_head_s),
    .rd_ptr_o (fifo_rd_ptr_s),
    .wr_ptr_o (fifo_wr_ptr_s),
    .count_o  (fifo_count_s)
  );

  // Master selection: round-robin in IDLE, locked to one master while holding.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_id_s    = ARB_M0;
    case (state_q)
      ARB_IDLE: begin
        if (m0_req_i && m1_req_i) begin
          sel_valid_s = 1'b1;
          sel_id_s    = rr_q;
        end else if (m0_req_i) begin
          sel_valid_s = 1'b1;
          sel_id_s    = ARB_M0;
        end else if (m1_req_i) begin
          sel_valid_s = 1'b1;
          sel_id_s    = ARB_M1;
        end else begin
          sel_valid_s = 1'b0;
          sel_id_s    = ARB_M0;
        end
      end
      ARB_HOLD_M0: begin
        sel_valid_s = m0_req_i;
        sel_id_s    = ARB_M0;
      end
      ARB_HOLD_M1: begin
        sel_valid_s = m1_req_i;
        sel_id_s    = ARB_M1;
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_id_s    = ARB_M0;
      end
    endcase
  end

  // A full FIFO blocks the request outright, independent of a same-cycle pop,
  // so rvalid never feeds combinationally into instr_req_o.
  assign sel_addr_s = (sel_id_s == ARB_M1) ? m1_addr_i : m0_addr_i;
  assign req_s      = sel_valid_s && !fifo_full_s && !rst;
  assign gnt_fire_s = req_s && instr_gnt_i;
  assign pop_s      = instr_rvalid_i && !fifo_empty_s && !rst;

  // FSM, round-robin pointer and sticky error next-state.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (gnt_fire_s) begin
      state_d = ARB_IDLE;
      rr_d    = arb_other(sel_id_s);
    end else if (sel_valid_s) begin
      state_d = (sel_id_s == ARB_M1) ? ARB_HOLD_M1 : ARB_HOLD_M0;
      rr_d    = rr_q;
    end else begin
      state_d = ARB_IDLE;
      rr_d    = rr_q;
    end
    err_d = err_q || (instr_rvalid_i && fifo_empty_s);
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      rr_q    <= ARB_M0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign instr_req_o  = req_s;
  assign instr_addr_o = req_s ? sel_addr_s : '0;
  assign m0_gnt_o     = gnt_fire_s && (sel_id_s == ARB_M0);
  assign m1_gnt_o     = gnt_fire_s && (sel_id_s == ARB_M1);
  assign m0_rvalid_o  = pop_s && (fifo_head_s == ARB_M0);
  assign m1_rvalid_o  = pop_s && (fifo_head_s == ARB_M1);
  assign m0_rdata_o   = rst ? '0 : instr_rdata_i;
  assign m1_rdata_o   = rst ? '0 : instr_rdata_i;
  // Pointers differ only while entries are outstanding (equal when empty or full).
  assign busy_o       = (state_q != ARB_IDLE) || (fifo_count_s != '0) ||
                        (fifo_rd_ptr_s != fifo_wr_ptr_s);
  assign err_o        = err_q;

endmodule

// File: tb/tb_riscv_instr_mem_arbiter.sv
// Scoreboard bench for riscv_instr_mem_arbiter: expected owners queued on grant,
// checked against master rvalids when the bench returns memory responses.
module tb_riscv_instr_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  riscv_instr_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs after the falling edge, check outputs 1ns later.
  task automatic cyc(input logic r0, input logic [31:0] a0,
                     input logic r1, input logic [31:0] a1,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic eg0, input logic eg1,
                     input logic ereq, input logic [31:0] eaddr);
    logic owner;
    @(negedge clk);
    m0_req_i = r0; m0_addr_i = a0;
    m1_req_i = r1; m1_addr_i = a1;
    instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd;
    #1;
    check_eq("instr_req", 64'(instr_req_o), 64'(ereq));
    if (ereq) check_eq("instr_addr", 64'(instr_addr_o), 64'(eaddr));
    check_eq("m0_gnt", 64'(m0_gnt_o), 64'(eg0));
    check_eq("m1_gnt", 64'(m1_gnt_o), 64'(eg1));
    if (rv && exp_q.size() > 0) begin
      owner = exp_q.pop_front();
      check_eq("m0_rvalid", 64'(m0_rvalid_o), 64'(owner == 1'b0));
      check_eq("m1_rvalid", 64'(m1_rvalid_o), 64'(owner == 1'b1));
      check_eq("m0_rdata", 64'(m0_rdata_o), 64'(rd));
      check_eq("m1_rdata", 64'(m1_rdata_o), 64'(rd));
    end else begin
      check_eq("m0_rvalid_none", 64'(m0_rvalid_o), 64'(1'b0));
      check_eq("m1_rvalid_none", 64'(m1_rvalid_o), 64'(1'b0));
    end
    if (eg0) exp_q.push_back(1'b0);
    if (eg1) exp_q.push_back(1'b1);
  endtask

  task automatic idle_check_busy(input string tag, input logic exp_busy);
    @(negedge clk);
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    #1;
    check_eq(tag, 64'(busy_o), 64'(exp_busy));
  endtask

  initial begin
    rst = 1'b1;
    m0_req_i = 1'b1; m0_addr_i = 32'h1234;
    m1_req_i = 1'b0; m1_addr_i = 32'h0;
    instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = 32'hFFFF_FFFF;
    #2;
    check_eq("rst_req", 64'(instr_req_o), 64'(1'b0));
    check_eq("rst_addr", 64'(instr_addr_o), 64'h0);
    check_eq("rst_gnt0", 64'(m0_gnt_o), 64'(1'b0));
    check_eq("rst_rdata0", 64'(m0_rdata_o), 64'h0);
    check_eq("rst_busy", 64'(busy_o), 64'(1'b0));
    check_eq("rst_err", 64'(err_o), 64'(1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; m0_req_i = 1'b0; instr_gnt_i = 1'b0;

    // Both masters requesting, gnt always high: alternate m0,m1; rvalid one cycle later.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'(32'h1000 + i * 4), 1'b1, 32'(32'h2000 + i * 4), 1'b1,
          (i > 0), 32'(32'hA0 + i - 1), (i % 2 == 0), (i % 2 == 1), 1'b1,
          (i % 2 == 0) ? 32'(32'h1000 + i * 4) : 32'(32'h2000 + i * 4));
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_check_busy("busy_after_rr", 1'b0);

    // m0 stalled three cycles with an address change; m1 locked out until after.
    cyc(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100);
    cyc(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100);
    cyc(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
    cyc(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200);
    cyc(1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Two outstanding: third request blocked even with a same-cycle rvalid.
    cyc(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h10);
    cyc(1'b1, 32'h14, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h14);
    cyc(1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h18, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h18);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC2, 1'b0, 1'b0, 1'b0, 32'h0);

    // Back-to-back m0 fetches, then a branch: both stale responses still go to m0.
    cyc(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40);
    cyc(1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44);
    idle_check_busy("busy_outstanding", 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_check_busy("busy_after_branch", 1'b0);

    // Unexpected rvalid with empty FIFO: nobody sees it, err sticks.
    check_eq("err_before", 64'(err_o), 64'(1'b0));
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_check_busy("busy_after_unexp", 1'b0);
    idle_check_busy("busy_after_unexp2", 1'b0);
    check_eq("err_sticky", 64'(err_o), 64'(1'b1));

    // Two outstanding (m1 then m0), then m1 parks in HOLD_M1 blocked; reset mid-flight.
    cyc(1'b0, 32'h0,  1'b1, 32'h60, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h60);
    cyc(1'b1, 32'h50, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h50);
    cyc(1'b0, 32'h0,  1'b1, 32'h64, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    m0_req_i = 1'b1; m1_req_i = 1'b1; instr_gnt_i = 1'b1;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h55; rst = 1'b1;
    #1;
    check_eq("mid_rst_req", 64'(instr_req_o), 64'(1'b0));
    check_eq("mid_rst_addr", 64'(instr_addr_o), 64'h0);
    check_eq("mid_rst_gnt0", 64'(m0_gnt_o), 64'(1'b0));
    check_eq("mid_rst_gnt1", 64'(m1_gnt_o), 64'(1'b0));
    check_eq("mid_rst_rv0", 64'(m0_rvalid_o), 64'(1'b0));
    check_eq("mid_rst_rv1", 64'(m1_rvalid_o), 64'(1'b0));
    check_eq("mid_rst_rdata1", 64'(m1_rdata_o), 64'h0);
    check_eq("mid_rst_busy", 64'(busy_o), 64'(1'b0));
    check_eq("mid_rst_err", 64'(err_o), 64'(1'b0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_check_busy("busy_after_stale", 1'b0);
    check_eq("err_stale", 64'(err_o), 64'(1'b1));
    // After reset m0 is preferred again and the FSM starts from IDLE.
    cyc(1'b1, 32'h70, 1'b1, 32'h74, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h70);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_check_busy("busy_final", 1'b0);
    check_eq("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
